// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_ctrl                                              |
// | Description : Main control FSM of the multicycle MIPS core with a          |
// |               memory-wait watchdog.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       mem_timeout
);

   localparam logic [3:0] c_fetch  = 4'd0;
   localparam logic [3:0] c_decode = 4'd1;
   localparam logic [3:0] c_memadr = 4'd2;
   localparam logic [3:0] c_memrd  = 4'd3;
   localparam logic [3:0] c_memwb  = 4'd4;
   localparam logic [3:0] c_memwr  = 4'd5;
   localparam logic [3:0] c_rtex   = 4'd6;
   localparam logic [3:0] c_rtwb   = 4'd7;
   localparam logic [3:0] c_beqex  = 4'd8;
   localparam logic [3:0] c_addiex = 4'd9;
   localparam logic [3:0] c_addiwb = 4'd10;
   localparam logic [3:0] c_jex    = 4'd11;

   localparam logic [5:0] c_op_lw   = 6'b100011;
   localparam logic [5:0] c_op_sw   = 6'b101011;
   localparam logic [5:0] c_op_rtyp = 6'b000000;
   localparam logic [5:0] c_op_beq  = 6'b000100;
   localparam logic [5:0] c_op_addi = 6'b001000;
   localparam logic [5:0] c_op_j    = 6'b000010;

   localparam int c_cnt_w = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MEM_TIMEOUT);

   logic [3:0]         r_state;
   logic [3:0]         w_state_next;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_next;
   logic               r_timeout;
   logic               w_waiting;
   logic               w_stalled;
   logic               w_pcwrite;
   logic               w_branch;
   logic               w_op_legal;

   assign w_op_legal = (op == c_op_lw)   || (op == c_op_sw)  || (op == c_op_rtyp) ||
                       (op == c_op_beq)  || (op == c_op_addi) || (op == c_op_j);

   // Next-state logic
   always_comb begin
      w_state_next = c_fetch;
      case (r_state)
         c_fetch:  w_state_next = mem_ready ? c_decode : c_fetch;
         c_decode: begin
            case (op)
               c_op_lw, c_op_sw: w_state_next = c_memadr;
               c_op_rtyp:        w_state_next = c_rtex;
               c_op_beq:         w_state_next = c_beqex;
               c_op_addi:        w_state_next = c_addiex;
               c_op_j:           w_state_next = c_jex;
               default:          w_state_next = c_fetch;
            endcase
         end
         c_memadr: w_state_next = (op == c_op_lw) ? c_memrd : c_memwr;
         c_memrd:  w_state_next = mem_ready ? c_memwb : c_memrd;
         c_memwb:  w_state_next = c_fetch;
         c_memwr:  w_state_next = mem_ready ? c_fetch : c_memwr;
         c_rtex:   w_state_next = c_rtwb;
         c_rtwb:   w_state_next = c_fetch;
         c_beqex:  w_state_next = c_fetch;
         c_addiex: w_state_next = c_addiwb;
         c_addiwb: w_state_next = c_fetch;
         c_jex:    w_state_next = c_fetch;
         default:  w_state_next = c_fetch;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_fetch;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Watchdog: a waiting state only exits on mem_ready, so clearing on
   // mem_ready also covers clearing on every state change.
   assign w_waiting = (r_state == c_fetch) || (r_state == c_memrd) || (r_state == c_memwr);
   assign w_stalled = w_waiting && !mem_ready;

   always_comb begin
      w_cnt_next = '0;
      if (w_stalled) begin
         w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         if (w_stalled && (w_cnt_next == c_cnt_max)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   // Output decode
   always_comb begin
      iord       = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (r_state)
         c_fetch: begin
            alusrcb   = 2'b01;
            irwrite   = mem_ready;
            w_pcwrite = mem_ready;
         end
         c_decode: begin
            alusrcb    = 2'b11;
            illegal_op = !w_op_legal;
         end
         c_memadr: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         c_memrd: begin
            iord = 1'b1;
         end
         c_memwb: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         c_memwr: begin
            iord       = 1'b1;
            memwrite   = 1'b1;
            instr_done = mem_ready;
         end
         c_rtex: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         c_rtwb: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         c_beqex: begin
            alusrca    = 1'b1;
            aluop      = 2'b01;
            pcsrc      = 2'b01;
            w_branch   = 1'b1;
            instr_done = 1'b1;
         end
         c_addiex: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         c_addiwb: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         c_jex: begin
            pcsrc      = 2'b10;
            w_pcwrite  = 1'b1;
            instr_done = 1'b1;
         end
         default: begin
            alusrcb = 2'b00;
         end
      endcase
   end

   assign pcen        = w_pcwrite | (w_branch & zero);
   assign state       = r_state;
   assign mem_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Directed bench for multicycle_ctrl; the watchdog limit is shortened to 4 cycles.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic       pcen;
   logic [3:0] state;
   logic       instr_done, illegal_op, mem_timeout;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
      .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .state(state),
      .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input logic [5:0] o);
      reset = 1'b1; op = o; zero = 1'b0; mem_ready = 1'b0;
      #3;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset(6'd0);
      reset = 1'b1;
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_state actual=%0d required=0", state); end
      checks++; if (alusrcb !== 2'b01) begin errors++; $display("FAIL rst_alusrcb actual=%b required=01", alusrcb); end
      checks++; if (irwrite !== 1'b0 || pcen !== 1'b0 || memwrite !== 1'b0 || regwrite !== 1'b0)
         begin errors++; $display("FAIL rst_strobes actual=%b%b%b%b required=0000", irwrite, pcen, memwrite, regwrite); end
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout actual=%b required=0", mem_timeout); end
      mem_ready = 1'b1;
      #1;
      checks++; if (irwrite !== 1'b1 || pcen !== 1'b1) begin errors++; $display("FAIL rst_fetch_ready actual=%b%b required=11", irwrite, pcen); end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_lw();
      logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      int done_cnt = 0;
      do_reset(6'b100011);
      mem_ready = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d] actual=%0d required=%0d", i, state, exp_st[i]); end
         checks++; if (regwrite !== (i == 4) || memtoreg !== (i == 4))
            begin errors++; $display("FAIL lw_wb[%0d] actual=%b%b required=%b%b", i, regwrite, memtoreg, i == 4, i == 4); end
         if (i < 5 && instr_done === 1'b1) done_cnt++;
         if (i == 3) begin
            checks++; if (iord !== 1'b1) begin errors++; $display("FAIL lw_iord actual=%b required=1", iord); end
         end
         if (i < 5) tick();
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL lw_done_count actual=%0d required=1", done_cnt); end
   endtask

   task automatic test_sw();
      int wr_cnt = 0;
      int done_cnt = 0;
      do_reset(6'b101011);
      mem_ready = 1'b1;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      #1;
      checks++; if (state !== 4'd5) begin errors++; $display("FAIL sw_state actual=%0d required=5", state); end
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin mem_ready = 1'b1; #1; end
         if (memwrite === 1'b1) wr_cnt++;
         if (instr_done === 1'b1) done_cnt++;
         checks++; if (iord !== 1'b1) begin errors++; $display("FAIL sw_iord[%0d] actual=%b required=1", i, iord); end
         checks++; if (instr_done !== (i == 2)) begin errors++; $display("FAIL sw_done[%0d] actual=%b required=%b", i, instr_done, i == 2); end
         tick();
      end
      checks++; if (wr_cnt != 3) begin errors++; $display("FAIL sw_memwrite_cycles actual=%0d required=3", wr_cnt); end
      checks++; if (state !== 4'd0 || memwrite !== 1'b0) begin errors++; $display("FAIL sw_end actual=%0d/%b required=0/0", state, memwrite); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL sw_done_count actual=%0d required=1", done_cnt); end
   endtask

   task automatic test_beq(input logic z);
      do_reset(6'b000100);
      mem_ready = 1'b1;
      zero = z;
      tick(); tick();
      checks++; if (state !== 4'd8) begin errors++; $display("FAIL beq_state actual=%0d required=8", state); end
      checks++; if (pcen !== z) begin errors++; $display("FAIL beq_pcen actual=%b required=%b", pcen, z); end
      checks++; if (pcsrc !== 2'b01 || aluop !== 2'b01 || alusrca !== 1'b1)
         begin errors++; $display("FAIL beq_ctl actual=%b/%b/%b required=01/01/1", pcsrc, aluop, alusrca); end
      checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL beq_done actual=%b required=1", instr_done); end
      tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL beq_return actual=%0d required=0", state); end
   endtask

   task automatic test_rtype_addi_j();
      do_reset(6'b000000);
      mem_ready = 1'b1;
      tick(); tick();
      checks++; if (state !== 4'd6 || aluop !== 2'b10 || alusrca !== 1'b1 || regwrite !== 1'b0)
         begin errors++; $display("FAIL rtex actual=%0d/%b/%b/%b required=6/10/1/0", state, aluop, alusrca, regwrite); end
      tick();
      checks++; if (state !== 4'd7 || regdst !== 1'b1 || regwrite !== 1'b1 || instr_done !== 1'b1)
         begin errors++; $display("FAIL rtwb actual=%0d/%b/%b/%b required=7/1/1/1", state, regdst, regwrite, instr_done); end
      do_reset(6'b001000);
      mem_ready = 1'b1;
      tick(); tick();
      checks++; if (state !== 4'd9 || alusrcb !== 2'b10 || alusrca !== 1'b1)
         begin errors++; $display("FAIL addiex actual=%0d/%b/%b required=9/10/1", state, alusrcb, alusrca); end
      tick();
      checks++; if (state !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0 || instr_done !== 1'b1)
         begin errors++; $display("FAIL addiwb actual=%0d/%b/%b/%b required=10/1/0/1", state, regwrite, regdst, instr_done); end
      do_reset(6'b000010);
      mem_ready = 1'b1;
      tick();
      checks++; if (alusrcb !== 2'b11) begin errors++; $display("FAIL decode_alusrcb actual=%b required=11", alusrcb); end
      tick();
      checks++; if (state !== 4'd11 || pcsrc !== 2'b10 || pcen !== 1'b1 || instr_done !== 1'b1)
         begin errors++; $display("FAIL jex actual=%0d/%b/%b/%b required=11/10/1/1", state, pcsrc, pcen, instr_done); end
      tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL j_return actual=%0d required=0", state); end
   endtask

   task automatic test_illegal();
      do_reset(6'b111111);
      mem_ready = 1'b1;
      tick();
      checks++; if (state !== 4'd1 || illegal_op !== 1'b1)
         begin errors++; $display("FAIL illegal_pulse actual=%0d/%b required=1/1", state, illegal_op); end
      checks++; if (regwrite !== 1'b0 || memwrite !== 1'b0)
         begin errors++; $display("FAIL illegal_strobes actual=%b%b required=00", regwrite, memwrite); end
      tick();
      checks++; if (state !== 4'd0 || illegal_op !== 1'b0)
         begin errors++; $display("FAIL illegal_next actual=%0d/%b required=0/0", state, illegal_op); end
   endtask

   task automatic test_timeout();
      do_reset(6'd0);
      tick(); tick(); tick();
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_early actual=%b required=0", mem_timeout); end
      tick();
      checks++; if (mem_timeout !== 1'b1 || irwrite !== 1'b0 || state !== 4'd0)
         begin errors++; $display("FAIL to_set actual=%b/%b/%0d required=1/0/0", mem_timeout, irwrite, state); end
      tick(); tick(); tick();
      mem_ready = 1'b1;
      tick();
      checks++; if (mem_timeout !== 1'b1 || state !== 4'd1)
         begin errors++; $display("FAIL to_sticky actual=%b/%0d required=1/1", mem_timeout, state); end
      // Ready arrives in the cycle the limit would be reached
      do_reset(6'd0);
      tick(); tick(); tick();
      mem_ready = 1'b1;
      tick();
      checks++; if (mem_timeout !== 1'b0 || state !== 4'd1)
         begin errors++; $display("FAIL to_boundary actual=%b/%0d required=0/1", mem_timeout, state); end
   endtask

   task automatic test_reset_mid_memwr();
      do_reset(6'b101011);
      mem_ready = 1'b1;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      tick(); tick(); tick(); tick();
      checks++; if (state !== 4'd5 || memwrite !== 1'b1 || mem_timeout !== 1'b1)
         begin errors++; $display("FAIL memwr_hold actual=%0d/%b/%b required=5/1/1", state, memwrite, mem_timeout); end
      #1;
      reset = 1'b1;
      #1;
      checks++; if (memwrite !== 1'b0 || state !== 4'd0 || mem_timeout !== 1'b0)
         begin errors++; $display("FAIL mid_reset actual=%b/%0d/%b required=0/0/0", memwrite, state, mem_timeout); end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      test_reset();
      test_lw();
      test_sw();
      test_beq(1'b1);
      test_beq(1'b0);
      test_rtype_addi_j();
      test_illegal();
      test_timeout();
      test_reset_mid_memwr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
